rvsteel_spi_target: RTL and testbench

SPI target (peripheral) that answers the SPI controller of the RISC-V Steel MCU, giving board tops a byte-wide register file reachable over `sclk`/`pico`/`poci`/`cs`. It implements SPI mode 0 (CPOL=0, CPHA=0), oversamples the bus with the system clock, and exposes the registers as a flat vector for LEDs, GPIO or test logic. It sits in the board top beside `rvsteel_mcu`, wired to the controller's SPI pins instead of leaving them unused.

---
 rtl/rvsteel_spi_target.sv | 152 +++++++++++++++
 tb/tb_rvsteel_spi_target.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rvsteel_spi_target.sv
// rtl/rvsteel_spi_target.sv - SPI mode 0 target exposing a byte-wide register file
// Oversamples sclk/pico/cs with the system clock; command byte selects direction and start address.
module rvsteel_spi_target #(
  parameter int REG_COUNT = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sclk,
  input  logic                   pico,
  output logic                   poci,
  input  logic                   cs,
  output logic [8*REG_COUNT-1:0] regs,
  output logic                   write_strobe,
  output logic [6:0]             write_address,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  state_t                 r_state;
  logic [2:0]             r_sclk_sync;
  logic [2:0]             r_cs_sync;
  logic [1:0]             r_pico_sync;
  logic [6:0]             r_shift;
  logic [2:0]             r_bit_count;
  logic [6:0]             r_addr;
  logic [7:0]             r_tx_byte;
  logic                   r_poci;
  logic [8*REG_COUNT-1:0] r_regs;
  logic                   r_write_strobe;
  logic [6:0]             r_write_address;
  logic                   r_busy;

  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_cs_rise;
  logic       w_cs_fall;
  logic       w_pico;
  logic       w_last_bit;
  logic [7:0] w_byte;
  logic [6:0] w_rd_addr;
  logic [7:0] w_rd_data;

  // cs sync resets low so a cs already held low after reset never looks like a falling edge
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sclk_sync <= 3'b000;
      r_cs_sync   <= 3'b000;
      r_pico_sync <= 2'b00;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], sclk};
      r_cs_sync   <= {r_cs_sync[1:0], cs};
      r_pico_sync <= {r_pico_sync[0], pico};
    end
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
  assign w_pico      = r_pico_sync[1];
  assign w_last_bit  = (r_bit_count == 3'd7);
  assign w_byte      = {r_shift, w_pico};
  assign w_rd_addr   = (r_state == CMD) ? w_byte[6:0] : r_addr;

  always_comb begin
    w_rd_data = 8'h00;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (w_rd_addr == 7'(i)) w_rd_data = r_regs[8*i +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= IDLE;
      r_shift         <= 7'd0;
      r_bit_count     <= 3'd0;
      r_addr          <= 7'd0;
      r_tx_byte       <= 8'h00;
      r_poci          <= 1'b0;
      r_regs          <= '0;
      r_write_strobe  <= 1'b0;
      r_write_address <= 7'd0;
      r_busy          <= 1'b0;
    end else begin
      r_write_strobe <= 1'b0;
      if (w_cs_rise) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_poci  <= 1'b0;
      end else if (w_cs_fall) begin
        r_state     <= CMD;
        r_bit_count <= 3'd0;
        r_busy      <= 1'b1;
        r_poci      <= 1'b0;
      end else begin
        case (r_state)
          CMD: begin
            if (w_sclk_rise) begin
              r_shift     <= w_byte[6:0];
              r_bit_count <= r_bit_count + 3'd1;
              if (w_last_bit) begin
                if (w_byte[7]) begin
                  r_state   <= READ;
                  r_tx_byte <= w_rd_data;
                  r_addr    <= w_byte[6:0] + 7'd1;
                end else begin
                  r_state <= WRITE;
                  r_addr  <= w_byte[6:0];
                end
              end
            end
          end
          WRITE: begin
            if (w_sclk_rise) begin
              r_shift     <= w_byte[6:0];
              r_bit_count <= r_bit_count + 3'd1;
              if (w_last_bit) begin
                for (int i = 0; i < REG_COUNT; i++) begin
                  if (r_addr == 7'(i)) r_regs[8*i +: 8] <= w_byte;
                end
                r_write_strobe  <= 1'b1;
                r_write_address <= r_addr;
                r_addr          <= r_addr + 7'd1;
              end
            end
          end
          READ: begin
            if (w_sclk_rise) begin
              r_bit_count <= r_bit_count + 3'd1;
              if (w_last_bit) begin
                r_tx_byte <= w_rd_data;
                r_addr    <= r_addr + 7'd1;
              end
            end else if (w_sclk_fall) begin
              // ~bit_count == 7 - bit_count: MSB goes out first
              r_poci <= r_tx_byte[~r_bit_count];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign poci          = r_poci;
  assign regs          = r_regs;
  assign write_strobe  = r_write_strobe;
  assign write_address = r_write_address;
  assign busy          = r_busy;

endmodule

// File: tb/tb_rvsteel_spi_target.sv
// tb/tb_rvsteel_spi_target.sv - directed bench for rvsteel_spi_target
module tb_rvsteel_spi_target;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sclk  = 1'b0;
  logic        pico  = 1'b0;
  logic        cs    = 1'b1;
  logic        poci;
  logic [63:0] regs;
  logic        write_strobe;
  logic [6:0]  write_address;
  logic        busy;

  int         n_total = 0;
  int         n_bad   = 0;
  int         n_strobe = 0;
  logic [6:0] strobe_addr [$];
  logic [7:0] rx;
  logic [7:0] rx_q [4];

  rvsteel_spi_target #(.REG_COUNT(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .sclk          (sclk),
    .pico          (pico),
    .poci          (poci),
    .cs            (cs),
    .regs          (regs),
    .write_strobe  (write_strobe),
    .write_address (write_address),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (write_strobe) begin
      n_strobe++;
      strobe_addr.push_back(write_address);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      pico = tx[7-i];
      tick(4);
      r = {r[6:0], poci};
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick(6);
  endtask

  task automatic cs_high();
    tick(6);
    cs = 1'b1;
    tick(6);
  endtask

  task automatic chk_strobe(input string tag, input int idx, input logic [6:0] exp);
    logic [6:0] a;
    a = (idx < strobe_addr.size()) ? strobe_addr[idx] : 7'h7f ^ exp;
    chk(tag, 64'(a), 64'(exp));
  endtask

  initial begin
    tick(4);
    reset = 1'b0;
    tick(10);
    chk("reset_regs", regs, 64'h0);
    chk("reset_poci", 64'(poci), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_waddr", 64'(write_address), 64'h0);
    chk("reset_strobes", 64'(n_strobe), 64'h0);

    // write 0x02: A5, 3C with busy edge timing
    cs = 1'b0;
    tick(2);
    chk("busy_rise_early", 64'(busy), 64'h0);
    tick(1);
    chk("busy_rise", 64'(busy), 64'h1);
    tick(3);
    spi_bits(8'h02, 8, rx);
    spi_bits(8'hA5, 8, rx);
    chk("write_poci_zero", 64'(rx), 64'h0);
    spi_bits(8'h3C, 8, rx);
    tick(6);
    cs = 1'b1;
    tick(2);
    chk("busy_fall_early", 64'(busy), 64'h1);
    tick(1);
    chk("busy_fall", 64'(busy), 64'h0);
    tick(6);
    chk("write_regs", regs, 64'h00000000_3CA50000);
    chk("write_nstrobe", 64'(n_strobe), 64'd2);
    chk_strobe("write_addr0", 0, 7'd2);
    chk_strobe("write_addr1", 1, 7'd3);

    // read burst from 2
    cs_low();
    for (int b = 0; b < 4; b++) begin
      spi_bits((b == 0) ? 8'h82 : 8'h00, 8, rx);
      rx_q[b] = rx;
    end
    cs_high();
    chk("read_cmd_poci", 64'(rx_q[0]), 64'h00);
    chk("read_b0", 64'(rx_q[1]), 64'hA5);
    chk("read_b1", 64'(rx_q[2]), 64'h3C);
    chk("read_b2", 64'(rx_q[3]), 64'h00);
    chk("read_poci_idle", 64'(poci), 64'h0);
    chk("read_nstrobe", 64'(n_strobe), 64'd2);
    chk("read_regs", regs, 64'h00000000_3CA50000);

    // out of range then wrap to 0
    cs_low();
    spi_bits(8'h7F, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    cs_high();
    chk("wrap_regs", regs, 64'h00000000_3CA50022);
    chk("wrap_nstrobe", 64'(n_strobe), 64'd4);
    chk_strobe("wrap_addr0", 2, 7'd127);
    chk_strobe("wrap_addr1", 3, 7'd0);

    // abort after 5 data bits
    cs_low();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'hFF, 5, rx);
    tick(6);
    cs = 1'b1;
    tick(3);
    chk("abort_busy", 64'(busy), 64'h0);
    tick(6);
    chk("abort_regs", regs, 64'h00000000_3CA50022);
    chk("abort_nstrobe", 64'(n_strobe), 64'd4);
    cs_low();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h77, 8, rx);
    cs_high();
    chk("after_abort_regs", regs, 64'h00000000_3CA57722);
    chk("after_abort_nstrobe", 64'(n_strobe), 64'd5);
    chk_strobe("after_abort_addr", 4, 7'd1);

    // reset in the middle of a write byte, cs stays low
    cs_low();
    spi_bits(8'h05, 8, rx);
    spi_bits(8'hC3, 5, rx);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    chk("midrst_regs", regs, 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_poci", 64'(poci), 64'h0);
    chk("midrst_waddr", 64'(write_address), 64'h0);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'hFF, 8, rx);
    chk("midrst_ignored_regs", regs, 64'h0);
    chk("midrst_ignored_busy", 64'(busy), 64'h0);
    chk("midrst_nstrobe", 64'(n_strobe), 64'd5);
    cs_high();
    cs_low();
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h5A, 8, rx);
    chk("midrst_next_busy", 64'(busy), 64'h1);
    cs_high();
    chk("midrst_next_regs", regs, 64'h00000000_0000005A);
    chk("midrst_next_nstrobe", 64'(n_strobe), 64'd6);
    chk_strobe("midrst_next_addr", 5, 7'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
